// File: rtl/mem_bus_ctrl.sv
// Two-master memory bus controller: round-robin arbitration, address decode into
// VGA/RAM windows and a req/ack device sequencer with timeout abort.
module mem_bus_ctrl #(
  parameter int unsigned word_width = 32,
  parameter int unsigned VGA_ADDR   = 224000,
  parameter int unsigned RAM_ADDR   = 1272576,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [word_width-1:0] m0_addr,
  input  logic [word_width-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [word_width-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [word_width-1:0] m1_addr,
  input  logic [word_width-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [word_width-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  vga_req,
  output logic                  vga_we,
  output logic [word_width-1:0] vga_addr,
  output logic [word_width-1:0] vga_wdata,
  input  logic                  vga_ack,
  input  logic [word_width-1:0] vga_rdata,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [word_width-1:0] ram_addr,
  output logic [word_width-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [word_width-1:0] ram_rdata,
  output logic                  busy
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [word_width-1:0] VGA_LIM = word_width'(VGA_ADDR);
  localparam logic [word_width-1:0] RAM_LIM = word_width'(RAM_ADDR);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {TGT_VGA, TGT_RAM, TGT_ERR} tgt_t;

  state_t                state;
  tgt_t                  tgt;
  logic                  gnt;
  logic                  last_grant;
  logic                  we_r;
  logic [word_width-1:0] off_r;
  logic [word_width-1:0] wdata_r;
  logic [CW-1:0]         cnt;

  logic                  sel;
  logic [word_width-1:0] sel_addr;
  tgt_t                  sel_tgt;
  logic [word_width-1:0] sel_off;
  logic                  dev_ack;
  logic [word_width-1:0] dev_rdata;
  logic                  timeout;
  logic                  resp_fire;
  logic                  resp_err;
  logic [word_width-1:0] resp_data;

  // On contention the master that was not granted last wins.
  always_comb begin
    sel      = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_addr = sel ? m1_addr : m0_addr;
    sel_tgt  = TGT_ERR;
    sel_off  = '0;
    if (sel_addr < VGA_LIM) begin
      sel_tgt = TGT_VGA;
      sel_off = sel_addr;
    end else if (sel_addr < RAM_LIM) begin
      sel_tgt = TGT_RAM;
      sel_off = sel_addr - VGA_LIM;
    end
  end

  // Only the granted device's ack counts, and only while waiting on it.
  always_comb begin
    dev_ack   = (tgt == TGT_RAM) ? ram_ack : ((tgt == TGT_VGA) ? vga_ack : 1'b0);
    dev_rdata = (tgt == TGT_RAM) ? ram_rdata : vga_rdata;
    timeout   = (cnt == CNT_LAST);
    resp_fire = ((state == ISSUE) && (tgt == TGT_ERR)) ||
                ((state == WAIT) && (dev_ack || timeout));
    resp_err  = !((state == WAIT) && dev_ack);
    resp_data = ((state == WAIT) && dev_ack && !we_r) ? dev_rdata : '0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= TGT_ERR;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      we_r       <= 1'b0;
      off_r      <= '0;
      wdata_r    <= '0;
      cnt        <= '0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
      vga_req    <= 1'b0;
      vga_we     <= 1'b0;
      vga_addr   <= '0;
      vga_wdata  <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt        <= sel;
            last_grant <= sel;
            tgt        <= sel_tgt;
            off_r      <= sel_off;
            we_r       <= sel ? m1_we : m0_we;
            wdata_r    <= sel ? m1_wdata : m0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (tgt == TGT_ERR) begin
            state <= RESP;
          end else begin
            if (tgt == TGT_VGA) begin
              vga_req   <= 1'b1;
              vga_we    <= we_r;
              vga_addr  <= off_r;
              vga_wdata <= wdata_r;
            end else begin
              ram_req   <= 1'b1;
              ram_we    <= we_r;
              ram_addr  <= off_r;
              ram_wdata <= wdata_r;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dev_ack || timeout) begin
            vga_req <= 1'b0;
            vga_we  <= 1'b0;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response is registered on the transition into RESP so ack/err/rdata line up.
      if (resp_fire) begin
        if (gnt) begin
          m1_ack   <= 1'b1;
          m1_err   <= resp_err;
          m1_rdata <= resp_data;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= resp_err;
          m0_rdata <= resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: masters push expected responses, a monitor
// pops them on each master ack, and behavioural devices check every access.
module tb_mem_bus_ctrl;

  localparam logic [31:0] VGA_A = 32'd224000;
  localparam logic [31:0] RAM_A = 32'd1272576;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        vga_req, vga_we;
  logic [31:0] vga_addr, vga_wdata;
  logic        vga_ack = 1'b0;
  logic [31:0] vga_rdata = '0;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .word_width(32), .VGA_ADDR(224000), .RAM_ADDR(1272576), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
    .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
  resp_t exp_q0[$];
  resp_t exp_q1[$];
  int    grant_log[$];

  // Device access each master is currently expecting (dev 0 = VGA, 1 = RAM).
  logic        pv[2];
  int          pdev[2];
  logic [31:0] poff[2];
  logic        pwe[2];
  logic [31:0] pwd[2];

  int   force_lat = -1;
  logic spur_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int dev_of(input logic [31:0] a);
    if (a < VGA_A) return 0;
    if (a < RAM_A) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] off_of(input logic [31:0] a);
    return (dev_of(a) == 1) ? a - VGA_A : a;
  endfunction

  function automatic logic [31:0] dev_data(input int d, input logic [31:0] off);
    return (off * 32'h9E3779B1) ^ ((d == 1) ? 32'h5A5A0000 : 32'h0000A5A5);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1: return 32'($urandom_range(0, 223999));
      2, 3: return VGA_A + 32'($urandom_range(0, 1048575));
      4: begin
        case ($urandom_range(0, 5))
          0: return 32'd0;
          1: return VGA_A - 1;
          2: return VGA_A;
          3: return RAM_A - 1;
          4: return RAM_A;
          default: return 32'hFFFF_FFFF;
        endcase
      end
      default: return $urandom;
    endcase
  endfunction

  // Caller sits just after a rising edge; returns just after the edge ending RESP.
  task automatic master_txn(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic tmo, input int exp_lat,
                            input logic keep);
    resp_t e;
    int    d, n;
    logic  got;
    d       = dev_of(addr);
    e.err   = (d == 2) || tmo;
    e.rdata = (e.err || we) ? 32'h0 : dev_data(d, off_of(addr));
    pdev[m] = d; poff[m] = off_of(addr); pwe[m] = we; pwd[m] = wd; pv[m] = (d != 2);
    if (m == 0) begin
      exp_q0.push_back(e);
      m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      exp_q1.push_back(e);
      m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
    end
    n = 1;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL m%0d_ack_timeout: no ack within 2000 cycles, expected ack", m);
      if (m == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (exp_lat > 0) begin
      check($sformatf("m%0d_latency", m), n, exp_lat);
    end
    pv[m] = 1'b0;
    @(posedge clk);
    #1;
    if (!keep) begin
      if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  task automatic rand_master(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      logic k;
      k = (i < n - 1) && ($urandom_range(0, 1) == 1);
      master_txn(m, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 0, k);
      if (!k) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rr_master(input int m, input logic [31:0] a);
    master_txn(m, 1'b0, a, $urandom, 1'b0, 0, 1'b1);
    master_txn(m, 1'b0, a + 4, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic match_access(input int d, input logic [31:0] a, input logic we,
                              input logic [31:0] wd);
    logic ok;
    ok = 1'b0;
    for (int m = 0; m < 2; m++)
      if (pv[m] && pdev[m] == d && poff[m] == a && pwe[m] == we && pwd[m] == wd) ok = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dev_access: dev=%0d addr=%h we=%b wdata=%h, expected m0 off=%h or m1 off=%h",
               d, a, we, wd, poff[0], poff[1]);
    end
  endtask

  // Behavioural devices: ack after a chosen number of WAIT cycles, optional stray acks.
  logic        dact[2] = '{1'b0, 1'b0};
  int          dcnt[2], dlat[2];
  int          held[2] = '{0, 0};
  logic        cap_we[2];
  logic [31:0] cap_a[2], cap_wd[2];
  logic        d_rq, d_we, d_ak;
  logic [31:0] d_a, d_wd, d_rd;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      d_rq = (d == 0) ? vga_req : ram_req;
      d_we = (d == 0) ? vga_we : ram_we;
      d_a  = (d == 0) ? vga_addr : ram_addr;
      d_wd = (d == 0) ? vga_wdata : ram_wdata;
      d_ak = 1'b0;
      d_rd = $urandom;
      if (rst) begin
        dact[d] = 1'b0;
      end else if (d_rq) begin
        if (!dact[d]) begin
          dact[d] = 1'b1;
          dcnt[d] = 0;
          dlat[d] = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
          cap_we[d] = d_we; cap_a[d] = d_a; cap_wd[d] = d_wd;
          match_access(d, d_a, d_we, d_wd);
        end else begin
          checks++;
          if ({d_we, d_a, d_wd} !== {cap_we[d], cap_a[d], cap_wd[d]}) begin
            errors++;
            $display("FAIL dev%0d_sideband_stable: we=%b addr=%h wdata=%h expected %b %h %h",
                     d, d_we, d_a, d_wd, cap_we[d], cap_a[d], cap_wd[d]);
          end
        end
        if (dcnt[d] == dlat[d]) begin
          d_ak = 1'b1;
          if (!d_we) d_rd = dev_data(d, d_a);
        end
        dcnt[d]++;
      end else begin
        if (dact[d]) begin
          held[d] = dcnt[d];
          dact[d] = 1'b0;
        end
        d_ak = spur_en && ($urandom_range(0, 7) == 0);
      end
      if (d == 0) begin vga_ack = d_ak; vga_rdata = d_rd; end
      else begin ram_ack = d_ak; ram_rdata = d_rd; end
    end
  end

  // Monitor: pops the scoreboard whenever a master ack is presented.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((vga_req && ram_req) || (m0_err && !m0_ack) || (m1_err && !m1_ack)) begin
        errors++;
        $display("FAIL bus_rules: vga_req=%b ram_req=%b m0_err=%b m0_ack=%b m1_err=%b m1_ack=%b, expected one req and err only with ack",
                 vga_req, ram_req, m0_err, m0_ack, m1_err, m1_ack);
      end
      if (m0_ack) begin
        grant_log.push_back(0);
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_unexpected_ack: ack=1 expected 0");
        end else begin
          resp_t e;
          e = exp_q0.pop_front();
          check("m0_rdata", m0_rdata, e.rdata);
          check("m0_err", {31'b0, m0_err}, {31'b0, e.err});
        end
      end
      if (m1_ack) begin
        grant_log.push_back(1);
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_unexpected_ack: ack=1 expected 0");
        end else begin
          resp_t e;
          e = exp_q1.pop_front();
          check("m1_rdata", m1_rdata, e.rdata);
          check("m1_err", {31'b0, m1_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    check("rst_dev_ctl", {vga_req, vga_we, ram_req, ram_we, busy}, 0);
    check("rst_dev_bus", vga_addr | vga_wdata | ram_addr | ram_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    force_lat = 0;
    master_txn(0, 1'b0, 32'd100, 32'h1111_2222, 1'b0, 4, 1'b0);
    master_txn(1, 1'b1, 32'd224004, 32'h55, 1'b0, 4, 1'b0);
    master_txn(0, 1'b0, RAM_A, 32'h0, 1'b0, 3, 1'b0);
    master_txn(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 3, 1'b0);
    master_txn(0, 1'b0, VGA_A - 1, 32'h0, 1'b0, 4, 1'b0);
    master_txn(1, 1'b0, RAM_A - 1, 32'h0, 1'b0, 4, 1'b0);

    force_lat = 100000;
    master_txn(0, 1'b0, VGA_A + 8, 32'h0, 1'b1, 258, 1'b0);
    check("timeout_req_cycles", held[1], 255);
    force_lat = 254;
    master_txn(0, 1'b0, VGA_A + 12, 32'h0, 1'b0, 258, 1'b0);
    check("late_ack_req_cycles", held[1], 255);

    force_lat = 100000;
    pdev[0] = 1; poff[0] = 32'd40; pwe[0] = 1'b0; pwd[0] = 32'h1234; pv[0] = 1'b1;
    m0_we = 1'b0; m0_addr = VGA_A + 40; m0_wdata = 32'h1234; m0_req = 1'b1;
    for (int i = 0; i < 20 && !ram_req; i++) @(negedge clk);
    check("rst_wait_reached", {31'b0, ram_req}, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wait", {ram_req, busy, m0_ack}, 0);
    m0_req = 1'b0;
    pv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    force_lat = 0;
    grant_log.delete();
    fork
      rr_master(0, 32'd200);
      rr_master(1, VGA_A + 32'd300);
    join
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("rr_order_%0d", i), grant_log[i], i % 2);

    grant_log.delete();
    rr_master(1, 32'd64);
    check("single_count", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++)
      check($sformatf("single_grant_%0d", i), grant_log[i], 1);

    force_lat = -1;
    spur_en = 1'b1;
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    spur_en = 1'b0;
    repeat (4) @(posedge clk);
    check("queues_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
